// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port block RAM between instruction fetch and load/store,
// hiding the registered read latency behind a req/done handshake.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                txn_we, txn_we_nxt;
  logic                owner_nxt;
  logic                busy_nxt;
  logic                if_done_nxt, d_done_nxt;
  logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;
  logic                mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_din_nxt;
  logic                grant_d_c;

  // D wins contention unless the streak limit forces a fetch through
  assign grant_d_c = d_req && (!if_req || (streak != STREAK_W'(MAX_STREAK)));

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      cnt      <= '0;
      txn_we   <= 1'b0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state    <= state_nxt;
      streak   <= streak_nxt;
      cnt      <= cnt_nxt;
      txn_we   <= txn_we_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
      if_done  <= if_done_nxt;
      d_done   <= d_done_nxt;
      if_rdata <= if_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
      mem_en   <= mem_en_nxt;
      mem_we   <= mem_we_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
    end
  end

  // Next-state, arbitration and output logic
  always_comb begin
    state_nxt    = state;
    streak_nxt   = streak;
    cnt_nxt      = cnt;
    txn_we_nxt   = txn_we;
    owner_nxt    = owner;
    if_done_nxt  = 1'b0;
    d_done_nxt   = 1'b0;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    mem_en_nxt   = 1'b0;
    mem_we_nxt   = 1'b0;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt  = ACCESS;
          mem_en_nxt = 1'b1;
          if (grant_d_c) begin
            owner_nxt    = 1'b1;
            txn_we_nxt   = d_we;
            mem_we_nxt   = d_we;
            mem_addr_nxt = d_addr;
            mem_din_nxt  = d_wdata;
            // A grant made here is always below the limit, so no saturation is needed
            streak_nxt   = if_req ? (streak + STREAK_W'(1)) : '0;
          end else begin
            owner_nxt    = 1'b0;
            txn_we_nxt   = 1'b0;
            mem_we_nxt   = 1'b0;
            mem_addr_nxt = if_addr;
            mem_din_nxt  = '0;
            streak_nxt   = '0;
          end
        end
      end

      ACCESS: begin
        if (txn_we) begin
          state_nxt  = DONE;
          d_done_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(READ_LAT - 1);
        end
      end

      WAIT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          if (owner) begin
            d_rdata_nxt = mem_dout;
            d_done_nxt  = 1'b1;
          end else begin
            if_rdata_nxt = mem_dout;
            if_done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port block RAM between two requesters: the instruction-fetch unit (IF) and the load/store unit (D).
- Handles one transaction at a time.
- Data accesses have priority; a streak limit guarantees fetch progress.
- Sits between the Processor datapath and the blk_mem_gen instance, and hides the RAM's registered read latency behind a req/done handshake.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width.
- READ_LAT, 1, RAM read latency in cycles from the mem_en cycle to mem_dout valid (range 1..3).
- MAX_STREAK, 4, maximum consecutive D grants while if_req is pending before IF is forced to win (range 1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch word address.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word; held until the next if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse; load data valid, or store committed.
- d_rdata  out  DATA_W  load data; held until the next load d_done.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_din  out  DATA_W  RAM write data (registered).
- mem_dout  in  DATA_W  RAM read data.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  0 = IF, 1 = D; owner of the current or last transaction.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - All outputs go to 0, state to IDLE, and the streak counter to 0.
  - Applied mid-transaction, reset abandons the access: no done pulse is issued for it, and any mem_dout returning later is ignored.
- States:
  - IDLE: requests are sampled.
  - ACCESS: mem_en is high for exactly one cycle.
  - WAIT: latency countdown; reads only.
  - DONE: done pulse; return to IDLE.
- Arbitration (evaluated in IDLE only):
  - If only one of if_req / d_req is high, that requester wins.
  - If both are high, D wins unless streak == MAX_STREAK, in which case IF wins.
  - streak increments on each D grant made while if_req is high; saturates at MAX_STREAK.
  - streak clears to 0 on any IF grant, and on a D grant made while if_req is low.
- Timing, with the request sampled in IDLE cycle T:
  - Cycle T+1 (ACCESS): mem_en=1, and mem_addr/mem_we/mem_din are registered from the winner. mem_we=0 and mem_din=0 for IF.
  - Store: DONE in cycle T+2 and d_done=1. d_rdata is unchanged.
  - Load or fetch: WAIT for READ_LAT cycles. mem_dout is captured into *_rdata at the edge ending cycle T+1+READ_LAT. DONE in cycle T+2+READ_LAT, and *_done=1 in that cycle only.
  - The cycle after DONE is IDLE. A req still high there is treated as a new request.
- Throughput: one access per 3+READ_LAT cycles for reads, and one per 3 cycles for writes.
- Request stability: requester inputs must be stable from assertion through done. The arbiter latches address and data in the ACCESS registers, so changes after T have no effect.
- Outside ACCESS, mem_en=0 and mem_we=0. mem_addr and mem_din hold their last values.
- The losing requester is not acknowledged; it waits in IDLE arbitration.

Test Plan:
- Reset: rst=1 for 3 cycles with if_req=1 → all outputs 0, no mem_en. Release at cycle R → mem_en=1 at R+1, and if_done at R+3 with if_rdata equal to RAM[if_addr].
- Single fetch: preload RAM[0x005]=0xDEADBEEF, if_req at T with if_addr=5 → mem_en at T+1 only, if_done at T+3, if_rdata=0xDEADBEEF held afterwards.
- Store then load: d_we=1, d_addr=0x010, d_wdata=0x12345678 → d_done at T+2. Then a load from 0x010 → d_rdata=0x12345678 after 3 cycles.
- Contention and starvation: if_req and d_req held continuously, D issuing back-to-back loads → grant order is D,D,D,D,IF,D,D,D,D,IF; owner sequence is checked.
- Reset mid-read: rst asserted in the WAIT/DONE-1 cycle of a load → no d_done, d_rdata=0, state IDLE, and the next request is served normally.
- READ_LAT=3 build: fetch at T → if_done at T+5; back-to-back fetch spacing is 6 cycles.
